// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
//
// Conditions a raw mechanical push-button pad into a clean pressed level,
// single-cycle press/release pulses and a saturating hold-time counter.
// The raw pad goes through a two-flop synchronizer and a polarity fix. It then
// feeds a four-state filter that only accepts a level after DEBOUNCE_MS
// consecutive stable cycles. The clock is a 1 kHz tick, so one cycle is 1 ms.
//
// Parameters
//   DEBOUNCE_MS   : stable cycles needed to accept a change (>= 2)
//   HOLD_W        : width of hold_ms
//   ACTIVE_LOW_IN : 1 -> pad reads 0 when pressed
//
// Ports
//   clk       in   system clock (1 kHz tick)
//   reset     in   asynchronous, active-low reset
//   btn_raw   in   unsynchronized pad level
//   btn_level out  debounced pressed level (1 = pressed)
//   btn_rise  out  one-cycle pulse when a press is accepted
//   btn_fall  out  one-cycle pulse when a release is accepted
//   hold_ms   out  cycles since press acceptance, saturating at all-ones
// -----------------------------------------------------------------------------
module button_debounce #(
  parameter int   DEBOUNCE_MS   = 20,
  parameter int   HOLD_W        = 16,
  parameter logic ACTIVE_LOW_IN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_raw,
  output logic              btn_level,
  output logic              btn_rise,
  output logic              btn_fall,
  output logic [HOLD_W-1:0] hold_ms
);

  typedef enum logic [1:0] {
    RELEASED,
    ARMING,
    PRESSED,
    DISARMING
  } state_e;

  // The counter only ever needs to reach DEBOUNCE_MS-1.
  localparam int                CNT_W    = $clog2(DEBOUNCE_MS);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_MS - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = '1;
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
  // Pad value that means "not pressed" is the polarity bit itself.
  localparam logic              IDLE_PAD = ACTIVE_LOW_IN;

  logic              sync1_q, sync2_q;
  logic              s;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [HOLD_W-1:0] hold_inc;

  // ---------------------------------------------------------------------------
  // Synchronizer
  // ---------------------------------------------------------------------------
  // NOTE: the sync flops reset to the idle pad value, not to 0. With an
  // active-low pad, a 0 would look like a press that is already in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= IDLE_PAD;
      sync2_q <= IDLE_PAD;
    end else begin
      // NOTE: non-blocking assignments make sync2_q take the old sync1_q.
      // This is what forms the two-stage chain.
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // s = 1 means pressed, independent of pad polarity.
  assign s = sync2_q ^ ACTIVE_LOW_IN;

  assign hold_inc = (hold_q == HOLD_MAX) ? hold_q : hold_q + HOLD_ONE;

  // ---------------------------------------------------------------------------
  // State register (filter state, counter and registered outputs)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      hold_q  <= hold_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default here first. This way no path through
    // the case can leave a variable unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    hold_d  = hold_q;

    unique case (state_q)
      RELEASED: begin
        hold_d = '0;
        if (s) begin
          state_d = ARMING;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end

      ARMING: begin
        if (!s) begin
          // Glitch shorter than the window: drop it silently.
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          rise_d  = 1'b1;
          hold_d  = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end

      PRESSED: begin
        hold_d = hold_inc;
        if (!s) begin
          state_d = DISARMING;
          cnt_d   = CNT_ONE;
        end
      end

      DISARMING: begin
        if (s) begin
          // Release glitch: stay pressed, hold time continues uninterrupted.
          state_d = PRESSED;
          cnt_d   = '0;
          hold_d  = hold_inc;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RELEASED;
          cnt_d   = '0;
          fall_d  = 1'b1;
          hold_d  = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          hold_d  = hold_inc;
        end
      end

      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
        hold_d  = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    btn_level = (state_q == PRESSED) || (state_q == DISARMING);
    btn_rise  = rise_q;
    btn_fall  = fall_q;
    hold_ms   = hold_q;
  end

endmodule

// File: tb/tb_button_debounce.sv
// -----------------------------------------------------------------------------
// tb_button_debounce
//
// Self-checking bench for button_debounce. There are three instances:
//   dut     : defaults (active-low pad, 16-bit hold)
//   dut_sat : HOLD_W = 4, shares pad and reset with dut
//   dut_pol : ACTIVE_LOW_IN = 0, driven from its own pad
// Pad segments come from a table. Every segment long enough to be accepted
// pushes the edge at which its pulse must appear. A monitor runs on each
// falling clock edge. It pops those events and checks the pulses, the level
// and hold_ms against the bench's own expectation.
// -----------------------------------------------------------------------------
module tb_button_debounce;

  localparam int D     = 20;
  localparam int SAT_W = 4;
  localparam int SAT_MAX = (1 << SAT_W) - 1;

  logic clk     = 1'b0;
  logic reset   = 1'b0;
  logic btn_raw = 1'b1;
  logic raw_pol = 1'b0;

  logic             lvl, rise, fall;
  logic [15:0]      hold;
  logic             s_lvl, s_rise, s_fall;
  logic [SAT_W-1:0] s_hold;
  logic             p_lvl, p_rise, p_fall;
  logic [15:0]      p_hold;

  button_debounce #(.DEBOUNCE_MS(D), .HOLD_W(16), .ACTIVE_LOW_IN(1'b1)) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw),
    .btn_level(lvl), .btn_rise(rise), .btn_fall(fall), .hold_ms(hold)
  );

  button_debounce #(.DEBOUNCE_MS(D), .HOLD_W(SAT_W), .ACTIVE_LOW_IN(1'b1)) dut_sat (
    .clk(clk), .reset(reset), .btn_raw(btn_raw),
    .btn_level(s_lvl), .btn_rise(s_rise), .btn_fall(s_fall), .hold_ms(s_hold)
  );

  button_debounce #(.DEBOUNCE_MS(D), .HOLD_W(16), .ACTIVE_LOW_IN(1'b0)) dut_pol (
    .clk(clk), .reset(reset), .btn_raw(raw_pol),
    .btn_level(p_lvl), .btn_rise(p_rise), .btn_fall(p_fall), .hold_ms(p_hold)
  );

  initial forever #5 clk = ~clk;

  // Number of rising edges seen so far.
  int edge_cnt = 0;
  initial forever begin
    @(posedge clk);
    edge_cnt++;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Scoreboard of expected pulses.
  typedef struct {
    bit is_rise;
    int at_edge;
  } evt_t;

  evt_t sb_q[$];
  evt_t e;
  bit   acc   = 1'b0;   // level the bench expects the filter to settle on
  bit   track = 1'b0;   // bench-side expected btn_level
  int   t0    = 0;      // edge of the expected press acceptance
  bit   exp_r, exp_f;
  int   held;
  int   pol_rise_cnt  = 0;
  int   pol_rise_edge = -1;

  // Monitor on the falling edge, away from the active edge.
  initial forever begin
    @(negedge clk);
    exp_r = 1'b0;
    exp_f = 1'b0;
    if (sb_q.size() != 0 && sb_q[0].at_edge == edge_cnt) begin
      e = sb_q.pop_front();
      exp_r = e.is_rise;
      exp_f = !e.is_rise;
    end
    check("rise", int'(rise), int'(exp_r));
    check("fall", int'(fall), int'(exp_f));
    check("sat_rise", int'(s_rise), int'(exp_r));
    check("sat_fall", int'(s_fall), int'(exp_f));
    if (exp_r) begin
      track = 1'b1;
      t0    = edge_cnt;
    end
    if (exp_f) track = 1'b0;
    held = track ? edge_cnt - t0 : 0;
    check("level", int'(lvl), int'(track));
    check("hold", int'(hold), held);
    check("sat_level", int'(s_lvl), int'(track));
    check("sat_hold", int'(s_hold), (held > SAT_MAX) ? SAT_MAX : held);
    if (p_rise) begin
      pol_rise_cnt++;
      pol_rise_edge = edge_cnt;
    end
  end

  // Drive one pad segment, starting at a falling edge. The pad changes just
  // after edge c, so an accepted change must pulse after edge c+2+D.
  task automatic apply_seg(input bit pressed, input int len);
    btn_raw = pressed ? 1'b0 : 1'b1;
    if (pressed != acc && len >= D) begin
      sb_q.push_back('{pressed, edge_cnt + 2 + D});
      acc = pressed;
    end
    repeat (len) @(negedge clk);
  endtask

  typedef struct {
    string name;
    bit    pressed;
    int    len;
    bit    exp_level;   // btn_level expected at the end of the segment
  } vec_t;

  vec_t vecs[13];
  int   c;

  initial begin
    vecs[0]  = '{"idle",          1'b0,  5, 1'b0};
    vecs[1]  = '{"clean_press",   1'b1, 45, 1'b1};
    vecs[2]  = '{"rel_glitch10",  1'b0, 10, 1'b1};
    vecs[3]  = '{"hold_a",        1'b1, 10, 1'b1};
    vecs[4]  = '{"rel_glitch19",  1'b0, 19, 1'b1};
    vecs[5]  = '{"hold_b",        1'b1, 10, 1'b1};
    vecs[6]  = '{"clean_release", 1'b0, 30, 1'b0};
    vecs[7]  = '{"bounce_p5",     1'b1,  5, 1'b0};
    vecs[8]  = '{"bounce_r3",     1'b0,  3, 1'b0};
    vecs[9]  = '{"bounce_p_hold", 1'b1, 30, 1'b1};
    vecs[10] = '{"release_20",    1'b0, 20, 1'b1};
    vecs[11] = '{"press_25",      1'b1, 25, 1'b1};
    vecs[12] = '{"release_30",    1'b0, 30, 1'b0};

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_level", int'(lvl), 0);
    check("reset_rise", int'(rise), 0);
    check("reset_fall", int'(fall), 0);
    check("reset_hold", int'(hold), 0);
    reset = 1'b1;

    // Table-driven segments.
    for (int i = 0; i < 13; i++) begin
      apply_seg(vecs[i].pressed, vecs[i].len);
      check({"seg_", vecs[i].name}, int'(lvl), int'(vecs[i].exp_level));
    end

    // Reset asserted mid-press clears everything at once, with no fall pulse.
    apply_seg(1'b1, 30);
    check("pre_reset_level", int'(lvl), 1);
    #2 reset = 1'b0;
    #1;
    check("midreset_level", int'(lvl), 0);
    check("midreset_fall", int'(fall), 0);
    check("midreset_hold", int'(hold), 0);
    check("midreset_sat_hold", int'(s_hold), 0);
    track = 1'b0;
    acc   = 1'b0;
    repeat (3) @(negedge clk);
    // Release reset with the button still held: a full debounce runs again.
    reset = 1'b0;
    reset = 1'b1;
    sb_q.push_back('{1'b1, edge_cnt + 2 + D});
    acc = 1'b1;
    repeat (30) @(negedge clk);
    check("post_reset_level", int'(lvl), 1);
    apply_seg(1'b0, 30);

    // Polarity: a constant 0 on the active-high instance means "released".
    check("pol_idle_level", int'(p_lvl), 0);
    check("pol_idle_rises", pol_rise_cnt, 0);
    check("pol_idle_fall", int'(p_fall), 0);
    check("pol_idle_hold", int'(p_hold), 0);
    raw_pol = 1'b1;
    c = edge_cnt;
    for (int i = 0; i < 40 && pol_rise_cnt == 0; i++) @(negedge clk);
    @(negedge clk);
    check("pol_rise_count", pol_rise_cnt, 1);
    check("pol_latency", pol_rise_edge, c + 2 + D);
    check("pol_level", int'(p_lvl), 1);

    // Drain and confirm every expected pulse was seen.
    repeat (5) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
